// File: rtl/hs_pkg.sv
// Shared definitions for the hs_slave_sink responder: address limit, checker states
// and the default FIFO entry layout.
package hs_pkg;

    localparam logic [7:0] HS_MAX_ADDR = 8'h30;
    localparam int         HS_WIDTH    = 8;

    typedef enum logic {
        SEQ_SYNC  = 1'b0,
        SEQ_TRACK = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [7:0]          addr;
        logic [HS_WIDTH-1:0] data;
    } hs_entry_t;

endpackage

// File: rtl/hs_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy; also reports the
// occupancy the current push/pop pair will produce so the owner can register ready.
module hs_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic [$clog2(DEPTH+1)-1:0] level_nxt_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0]  store_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;

    always_comb begin
        level_d = level_q;
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // Payload storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push_i) store_q[wr_ptr_q] <= din_i;
    end

    assign dout_o      = store_q[rd_ptr_q];
    assign level_o     = level_q;
    assign level_nxt_o = level_d;
    assign full_o      = (level_q == LW'(DEPTH));
    assign empty_o     = (level_q == '0);

endmodule

// File: rtl/hs_slave_sink.sv
// Responder end of the valid/ready link: buffers in-range beats and drains them into
// a register memory. Define SLAVE_SEQ_CHECK_EN to build the address-sequence checker.
module hs_slave_sink
    import hs_pkg::*;
#(
    parameter int         WIDTH    = 8,
    parameter int         DEPTH    = 4,
    parameter logic [7:0] MAX_ADDR = HS_MAX_ADDR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid,
    input  logic [7:0]                 addr,
    input  logic [WIDTH-1:0]           s_data_in,
    output logic                       ready,
    input  logic                       drain_en,
    input  logic [7:0]                 rd_addr,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic [15:0]                beat_cnt,
    output logic [7:0]                 drop_cnt,
    output logic                       seq_err
);

    localparam int LW        = $clog2(DEPTH+1);
    localparam int MEM_WORDS = int'(MAX_ADDR) + 1;
    localparam int MEM_AW    = $clog2(MEM_WORDS);

    typedef struct packed {
        logic [7:0]       addr;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic             ready_q, ready_d;
    logic [WIDTH-1:0] rd_data_q;
    logic [15:0]      beat_cnt_q;
    logic [7:0]       drop_cnt_q;
    logic [WIDTH-1:0] mem_q [MEM_WORDS];

    logic             accept, in_range, push, pop;
    logic             fifo_full, fifo_empty;
    logic [LW-1:0]    level, level_nxt;
    entry_t           head, tail;

    assign accept   = valid & ready_q;
    assign in_range = (addr <= MAX_ADDR);
    assign push     = accept & in_range & ~fifo_full;
    assign pop      = drain_en & ~fifo_empty;
    assign tail     = '{addr: addr, data: s_data_in};

    hs_sync_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .din_i       (tail),
        .pop_i       (pop),
        .dout_o      (head),
        .level_o     (level),
        .level_nxt_o (level_nxt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Ready looks one cycle ahead so the FIFO can never be overrun.
    assign ready_d = (level_nxt != LW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            beat_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            ready_q <= ready_d;
            if (accept) beat_cnt_q <= beat_cnt_q + 16'd1;
            if (accept && !in_range && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    // Memory survives reset; only in-range entries ever reach the FIFO head.
    always_ff @(posedge clk) begin
        if (pop && head.addr <= MAX_ADDR) mem_q[head.addr[MEM_AW-1:0]] <= head.data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= (rd_addr <= MAX_ADDR) ? mem_q[rd_addr[MEM_AW-1:0]] : '0;
    end

`ifdef SLAVE_SEQ_CHECK_EN
    seq_state_t seq_state_q;
    logic [7:0] exp_addr_q;
    logic       seq_err_q;

    function automatic logic [7:0] next_addr(input logic [7:0] a);
        return (a >= MAX_ADDR) ? 8'h00 : a + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_state_q <= SEQ_SYNC;
            exp_addr_q  <= '0;
            seq_err_q   <= 1'b0;
        end else if (accept) begin
            exp_addr_q <= next_addr(addr);
            case (seq_state_q)
                SEQ_SYNC:  seq_state_q <= SEQ_TRACK;
                SEQ_TRACK: if (addr != exp_addr_q) seq_err_q <= 1'b1;
                default:   seq_state_q <= SEQ_SYNC;
            endcase
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

    assign ready      = ready_q;
    assign rd_data    = rd_data_q;
    assign fifo_level = level;
    assign beat_cnt   = beat_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_hs_slave_sink.sv
// Directed bench for hs_slave_sink; honours SLAVE_SEQ_CHECK_EN for the seq_err expectations.
module tb_hs_slave_sink;

`ifdef SLAVE_SEQ_CHECK_EN
    localparam logic SEQ_ON = 1'b1;
`else
    localparam logic SEQ_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [7:0]  addr;
    logic [7:0]  s_data_in;
    logic        ready;
    logic        drain_en;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [2:0]  fifo_level;
    logic [15:0] beat_cnt;
    logic [7:0]  drop_cnt;
    logic        seq_err;

    int checks   = 0;
    int failures = 0;

    hs_slave_sink #(.WIDTH(8), .DEPTH(4), .MAX_ADDR(8'h30)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (valid),
        .addr       (addr),
        .s_data_in  (s_data_in),
        .ready      (ready),
        .drain_en   (drain_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .fifo_level (fifo_level),
        .beat_cnt   (beat_cnt),
        .drop_cnt   (drop_cnt),
        .seq_err    (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one beat and advance one edge; valid stays high for back-to-back use.
    task automatic beat(input logic [7:0] a, input logic [7:0] d);
        valid     = 1'b1;
        addr      = a;
        s_data_in = d;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        valid     = 1'b0;
        addr      = 8'h00;
        s_data_in = 8'h00;
        drain_en  = 1'b0;
        rd_addr   = 8'h00;

        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_beat", 32'(beat_cnt), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_seq_err", 32'(seq_err), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", 32'(ready), 32'd1);
        chk("rel_level", 32'(fifo_level), 32'd0);
        chk("rel_beat", 32'(beat_cnt), 32'd0);

        // Streaming with drain enabled: ready never drops.
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(8'(i), 8'hA0 + 8'(i));
            chk("stream_ready", 32'(ready), 32'd1);
        end
        valid = 1'b0;
        chk("stream_beat", 32'(beat_cnt), 32'd4);
        tick();
        tick();
        chk("stream_drained", 32'(fifo_level), 32'd0);
        rd_addr = 8'h02;
        tick();
        chk("rd_addr2", 32'(rd_data), 32'hA2);
        rd_addr = 8'h03;
        tick();
        chk("rd_addr3", 32'(rd_data), 32'hA3);

        // Fill with drain disabled until backpressure.
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(8'h10 + 8'(i), 8'h50 + 8'(i));
            chk("fill_level", 32'(fifo_level), 32'(i + 1));
            chk("fill_ready", 32'(ready), (i == 3) ? 32'd0 : 32'd1);
        end
        beat(8'h14, 8'h54);
        chk("held_ready", 32'(ready), 32'd0);
        chk("held_level", 32'(fifo_level), 32'd4);
        chk("held_beat", 32'(beat_cnt), 32'd8);
        drain_en = 1'b1;
        tick();
        chk("pop_full_ready", 32'(ready), 32'd1);
        chk("pop_full_level", 32'(fifo_level), 32'd3);
        chk("pop_full_beat", 32'(beat_cnt), 32'd8);
        tick();
        chk("pushpop_level", 32'(fifo_level), 32'd3);
        chk("pushpop_ready", 32'(ready), 32'd1);
        chk("pushpop_beat", 32'(beat_cnt), 32'd9);
        valid = 1'b0;
        tick();
        tick();
        tick();
        chk("fill_drained", 32'(fifo_level), 32'd0);
        rd_addr = 8'h14;
        tick();
        chk("rd_addr14", 32'(rd_data), 32'h54);

        // Out-of-range beat is accepted and dropped.
        drain_en = 1'b0;
        beat(8'h05, 8'h77);
        beat(8'h31, 8'hEE);
        valid = 1'b0;
        chk("oor_beat", 32'(beat_cnt), 32'd11);
        chk("oor_drop", 32'(drop_cnt), 32'd1);
        chk("oor_level", 32'(fifo_level), 32'd1);
        rd_addr = 8'h31;
        tick();
        chk("rd_oor", 32'(rd_data), 32'd0);

        // Pop edge writes memory; readback registers on the following edge.
        rd_addr  = 8'h05;
        drain_en = 1'b1;
        tick();
        chk("lat_level", 32'(fifo_level), 32'd0);
        tick();
        chk("lat_rd_data", 32'(rd_data), 32'h77);

        // Drop counter saturates.
        valid = 1'b1;
        addr  = 8'hFF;
        repeat (260) tick();
        valid = 1'b0;
        chk("sat_drop", 32'(drop_cnt), 32'hFF);
        chk("sat_beat", 32'(beat_cnt), 32'd271);
        chk("sat_ready", 32'(ready), 32'd1);

        // Reset mid-operation: FIFO and counters cleared, memory kept.
        drain_en = 1'b0;
        beat(8'h01, 8'h11);
        beat(8'h02, 8'h22);
        valid = 1'b0;
        chk("pre_rst_level", 32'(fifo_level), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_beat", 32'(beat_cnt), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
        tick();
        rst_n   = 1'b1;
        rd_addr = 8'h02;
        tick();
        chk("post_rst_ready", 32'(ready), 32'd1);
        tick();
        chk("mem_retained", 32'(rd_data), 32'hA2);
        chk("post_rst_level", 32'(fifo_level), 32'd0);

        // Address-sequence checker, including wrap at MAX_ADDR.
        drain_en = 1'b1;
        beat(8'h2F, 8'h01);
        beat(8'h30, 8'h02);
        beat(8'h00, 8'h03);
        chk("seq_wrap_ok", 32'(seq_err), 32'd0);
        beat(8'h02, 8'h04);
        chk("seq_break", 32'(seq_err), 32'(SEQ_ON));
        beat(8'h03, 8'h05);
        beat(8'h04, 8'h06);
        valid = 1'b0;
        chk("seq_sticky", 32'(seq_err), 32'(SEQ_ON));
        rst_n = 1'b0;
        #1;
        chk("seq_rst", 32'(seq_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
